inst_fetch: RTL and testbench

Front-end instruction issuer that produces the opcode stream the control unit decodes. It reads instruction words from program memory over a req/ack handshake and holds a program counter. Each word is presented to the decode stage over a valid/ready handshake. Opcode sits in the top 6 bits; the remaining bits pass through as operand/immediate. Output opcode is forced to NOP (6'b000000) whenever nothing valid is issued, so the decoder idles.

---
 rtl/inst_fetch.sv | 104 ++++++++++
 tb/tb_inst_fetch.sv | 125 ++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: program-memory instruction fetcher issuing opcode/operand words to decode
// Ports: clk/rst (sync, active-high); run enables fetching; pc_load/pc_load_val reload pc in IDLE/HALTED;
//   mem_req/mem_addr/mem_ack/mem_rdata form the program-memory read handshake;
//   issue_valid/issue_ready/issue_opcode/issue_operand present each word to decode (NOP when not valid);
//   pc is the program counter; halted flags a HALT stop.
// Optional: define INST_FETCH_HALT_EN to stop fetching on opcode 6'b111111 instead of issuing it.
module inst_fetch #(
  parameter int IW = 16,
  parameter int AW = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [5:0]    issue_opcode,
  output logic [IW-7:0] issue_operand,
  output logic [AW-1:0] pc,
  output logic          halted
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALTED} state_t;
  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic          r_req;
  logic          r_valid;
  logic [5:0]    r_op;
  logic [IW-7:0] r_opnd;
  logic          r_halted;
  logic          w_halt;
`ifdef INST_FETCH_HALT_EN
  assign w_halt = mem_rdata[IW-1:IW-6] == 6'h3f;
`else
  assign w_halt = 1'b0;
`endif
  // the instruction register is held directly as the opcode/operand output fields,
  // which are cleared on accept so decode sees NOP whenever nothing is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_opnd   <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pc_load) r_pc <= pc_load_val;
          else if (run) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_req <= 1'b0;
            r_pc  <= r_pc + 1'b1;
            if (w_halt) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_valid <= 1'b1;
              r_op    <= mem_rdata[IW-1:IW-6];
              r_opnd  <= mem_rdata[IW-7:0];
            end
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_opnd  <= '0;
            r_req   <= run;
            r_state <= run ? S_FETCH : S_IDLE;
          end
        end
        S_HALTED: begin
          if (pc_load) begin
            r_pc     <= pc_load_val;
            r_halted <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign mem_req       = r_req;
  assign mem_addr      = r_pc;
  assign pc            = r_pc;
  assign issue_valid   = r_valid;
  assign issue_opcode  = r_op;
  assign issue_operand = r_opnd;
  assign halted        = r_halted;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a transaction-level reference model
module tb_inst_fetch;
`ifdef INST_FETCH_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_load_val = '0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [5:0]  issue_opcode;
  logic [9:0]  issue_operand;
  logic [7:0]  pc;
  logic        halted;
  inst_fetch #(.IW(16), .AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
    .issue_operand(issue_operand), .pc(pc), .halted(halted)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [256];
  int n_checks = 0;
  int n_fail = 0;
  bit m_fetch = 1'b0, m_issue = 1'b0, m_halt = 1'b0;
  logic [7:0] m_pc = 8'h00;
  logic [15:0] m_word = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // one cycle: compare outputs with the model, apply inputs, advance the model across the edge
  task automatic step(input bit r, input bit rn, input bit rd, input bit ld, input logic [7:0] lv, input bit ak);
    check("mem_req", 32'(mem_req), 32'(m_fetch));
    check("mem_addr", 32'(mem_addr), 32'(m_pc));
    check("pc", 32'(pc), 32'(m_pc));
    check("issue_valid", 32'(issue_valid), 32'(m_issue));
    check("opcode", 32'(issue_opcode), m_issue ? 32'(m_word[15:10]) : 32'h0);
    check("operand", 32'(issue_operand), m_issue ? 32'(m_word[9:0]) : 32'h0);
    check("halted", 32'(halted), 32'(m_halt));
    rst = r; run = rn; issue_ready = rd; pc_load = ld; pc_load_val = lv; mem_ack = ak;
    mem_rdata = mem[mem_addr];
    if (r) begin
      m_fetch = 0; m_issue = 0; m_halt = 0; m_pc = 8'h00; m_word = '0;
    end else if (m_fetch) begin
      if (ak) begin
        m_word = mem[m_pc];
        m_pc = m_pc + 8'd1;
        m_fetch = 0;
        if (HALT && m_word[15:10] == 6'h3f) m_halt = 1; else m_issue = 1;
      end
    end else if (m_issue) begin
      if (rd) begin m_issue = 0; m_fetch = rn; end
    end else if (m_halt) begin
      if (ld) begin m_pc = lv; m_halt = 0; end
    end else if (ld) m_pc = lv;
    else if (rn) m_fetch = 1;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0412; mem[1] = 16'h0823; mem[2] = 16'hFC00; mem[3] = 16'h0000;
    mem[8'hFF] = 16'h1234; mem[8'h10] = 16'hFC55;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    // zero-wait memory, ready high: ADD, second word, then HALT word (halts or issues)
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 8'h00, 0);
    step(0, 0, 1, 0, 0, 0);
    // backpressure
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1);
    // slow memory with run dropped mid-wait
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, i == 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 1);
    // pc wrap and ignored pc_load during fetch
    step(0, 0, 1, 1, 8'hFF, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 8'h55, 0);
    step(0, 1, 1, 1, 8'h55, 1);
    step(0, 1, 1, 1, 8'h55, 0);
    step(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    // reset during pending fetch, late ack afterwards
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    // reset during issue
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    // halt word away from address 2
    step(0, 0, 1, 1, 8'h10, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 1);
    step(0, 0, 1, 1, 8'h20, 0);
    step(0, 0, 1, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 10, 8'($urandom), $urandom_range(0, 99) < 50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
